// File: rtl/tdm_channel_mux_pkg.sv
// tdm_pkg: mode encodings and index-width helper shared by the TDM mux files
package tdm_pkg;
    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_FIXED = 2'b01;
    localparam logic [1:0] MODE_RR    = 2'b10;
    localparam logic [1:0] MODE_VRR   = 2'b11;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/tdm_channel_mux_if.sv
// tdm_channel_mux_if: per-channel inputs and the registered serial output of the TDM mux
interface tdm_channel_mux_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8
);
    import tdm_pkg::*;
    localparam int CH_W = clog2_min1(NUM_CH);
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic [CH_W-1:0]          out_ch;
    logic                     slot_start;
    modport master (input ch_data, ch_valid, output out_data, out_valid, out_ch, slot_start);
    modport slave  (output ch_data, ch_valid, input out_data, out_valid, out_ch, slot_start);
endinterface

// File: rtl/tdm_channel_mux_rr_next_valid.sv
// rr_next_valid: cyclic search for the next set mask bit after ptr, ptr itself checked last
module rr_next_valid import tdm_pkg::*; #(
    parameter int NUM_CH = 3,
    localparam int CH_W = clog2_min1(NUM_CH)
) (
    input  logic [CH_W-1:0]   ptr,
    input  logic [NUM_CH-1:0] mask,
    output logic [CH_W-1:0]   nxt,
    output logic              found
);
    always_comb begin
        nxt = ptr;
        found = 1'b0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (mask[(int'(ptr) + i) % NUM_CH]) begin
                nxt = CH_W'((int'(ptr) + i) % NUM_CH);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tdm_channel_mux.sv
// tdm_channel_mux: N-channel time-division mux with fixed, timed round-robin and
// valid-skipping round-robin modes; all outputs registered.
module tdm_channel_mux import tdm_pkg::*; #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4,
    localparam int CH_W  = clog2_min1(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    tdm_channel_mux_if.master   bus,
    input  logic [1:0]          mode,
    input  logic [CH_W-1:0]     fixed_sel,
    input  logic [CNT_W-1:0]    switch_clk_cycles
);
    logic [CH_W-1:0]   ptr_q, ptr_d, ptr_e, nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_e, len_q, len_d, len_e;
    logic [1:0]        prev_mode_q, prev_mode_d;
    logic [DATA_W-1:0] out_data_q, out_data_d, sel_data;
    logic              out_valid_q, out_valid_d, slot_start_q, slot_start_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [NUM_CH-1:0] mask;
    logic              mode_chg, rr, wrap, in_rng, found;

    // Mode 10 searches an all-ones mask, which reduces to a plain ptr+1 wrap.
    assign mask = (mode == MODE_VRR) ? bus.ch_valid : '1;

    rr_next_valid #(.NUM_CH(NUM_CH)) u_next (.ptr(ptr_e), .mask(mask), .nxt(nxt), .found(found));

    always_comb begin
        mode_chg = mode != prev_mode_q;
        rr = mode[1];
        // A mode change restarts the slot on this very edge; entering RR from outside restarts at ch0.
        ptr_e = (mode == MODE_FIXED) ? fixed_sel : (mode_chg && rr && !prev_mode_q[1]) ? '0 : ptr_q;
        cnt_e = mode_chg ? '0 : cnt_q;
        len_e = (cnt_e == '0) ? ((switch_clk_cycles == '0) ? CNT_W'(1) : switch_clk_cycles) : len_q;
        wrap = cnt_e == len_e - CNT_W'(1);
        in_rng = int'(ptr_e) < NUM_CH;
        sel_data = in_rng ? bus.ch_data[int'(ptr_e)*DATA_W +: DATA_W] : '0;
        ptr_d = '0;
        cnt_d = '0;
        len_d = len_q;
        prev_mode_d = mode;
        out_data_d = '0;
        out_valid_d = 1'b0;
        out_ch_d = out_ch_q;
        slot_start_d = 1'b0;
        if (mode == MODE_FIXED) begin
            ptr_d = fixed_sel;
            out_data_d = sel_data;
            out_valid_d = in_rng;
            out_ch_d = fixed_sel;
        end else if (rr) begin
            cnt_d = wrap ? '0 : cnt_e + CNT_W'(1);
            len_d = len_e;
            ptr_d = (wrap && found) ? nxt : ptr_e;
            out_data_d = sel_data;
            out_valid_d = (mode == MODE_RR) || bus.ch_valid[ptr_e];
            out_ch_d = ptr_e;
            slot_start_d = cnt_e == '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
            prev_mode_q <= MODE_IDLE;
            out_data_q <= '0;
            out_valid_q <= 1'b0;
            out_ch_q <= '0;
            slot_start_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
            prev_mode_q <= prev_mode_d;
            out_data_q <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q <= out_ch_d;
            slot_start_q <= slot_start_d;
        end
    end

    assign bus.out_data = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch = out_ch_q;
    assign bus.slot_start = slot_start_q;
endmodule

// File: tb/tb_tdm_channel_mux.sv
// tb_tdm_channel_mux: directed checks of reset, fixed, timed RR, valid-skip RR, slot length and async reset
module tb_tdm_channel_mux;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] fixed_sel = '0;
    logic [3:0] switch_clk_cycles = 4'd6;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] dv [3];
    int         ch5 [19];
    int         sl5 [19];

    tdm_channel_mux_if #(.NUM_CH(3), .DATA_W(8)) bus ();

    tdm_channel_mux #(.NUM_CH(3), .DATA_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .mode(mode),
        .fixed_sel(fixed_sel), .switch_clk_cycles(switch_clk_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic [1:0] c, input logic s);
        chk({tag, ".data"}, 32'(bus.out_data), 32'(d));
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".ch"}, 32'(bus.out_ch), 32'(c));
        chk({tag, ".slot"}, 32'(bus.slot_start), 32'(s));
    endtask

    initial begin
        dv = '{8'hAA, 8'hBB, 8'hCC};
        ch5 = '{0,0,0,0,0,0,1,1,1,2,2,2,0,0,0,1,2,0,1};
        sl5 = '{1,0,0,0,0,0,1,0,0,1,0,0,1,0,0,1,1,1,1};
        bus.ch_data = {8'hCC, 8'hBB, 8'hAA};
        bus.ch_valid = 3'b000;
        tick();
        tick();
        chk_out("reset", 8'h00, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("idle", 8'h00, 1'b0, 2'd0, 1'b0);

        mode = 2'b10;
        for (int i = 0; i < 18; i++) begin
            tick();
            chk_out($sformatf("rr6[%0d]", i), dv[(i/6)%3], 1'b1, 2'((i/6)%3), i % 6 == 0);
        end

        tick();
        chk_out("live0", 8'hAA, 1'b1, 2'd0, 1'b1);
        tick();
        chk_out("live1", 8'hAA, 1'b1, 2'd0, 1'b0);
        bus.ch_data[7:0] = 8'hDD;
        tick();
        chk_out("live2", 8'hDD, 1'b1, 2'd0, 1'b0);
        tick();
        chk_out("live3", 8'hDD, 1'b1, 2'd0, 1'b0);
        bus.ch_data[7:0] = 8'hAA;

        mode = 2'b11;
        switch_clk_cycles = 4'd3;
        bus.ch_valid = 3'b101;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_out($sformatf("vrr[%0d]", i), (i/3 == 1) ? 8'hCC : 8'hAA, 1'b1, (i/3 == 1) ? 2'd2 : 2'd0, i % 3 == 0);
        end
        bus.ch_valid = 3'b000;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_out($sformatf("vrr_none[%0d]", i), 8'hCC, 1'b0, 2'd2, i % 3 == 0);
        end

        mode = 2'b01;
        fixed_sel = 2'd2;
        tick();
        chk_out("fixed2", 8'hCC, 1'b1, 2'd2, 1'b0);
        fixed_sel = 2'd3;
        tick();
        chk("fixed3.valid", 32'(bus.out_valid), 32'd0);
        chk("fixed3.data", 32'(bus.out_data), 32'd0);

        mode = 2'b10;
        switch_clk_cycles = 4'd6;
        for (int i = 0; i < 19; i++) begin
            tick();
            chk_out($sformatf("len[%0d]", i), dv[ch5[i]], 1'b1, 2'(ch5[i]), sl5[i] == 1);
            if (i == 1) switch_clk_cycles = 4'd3;
            if (i == 12) switch_clk_cycles = 4'd0;
        end

        switch_clk_cycles = 4'd6;
        tick();
        chk_out("pre_rst0", 8'hCC, 1'b1, 2'd2, 1'b1);
        tick();
        chk_out("pre_rst1", 8'hCC, 1'b1, 2'd2, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 8'h00, 1'b0, 2'd0, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        chk_out("post_rst0", 8'hAA, 1'b1, 2'd0, 1'b1);
        tick();
        chk_out("post_rst1", 8'hAA, 1'b1, 2'd0, 1'b0);

        mode = 2'b01;
        fixed_sel = 2'd1;
        tick();
        chk_out("fixed1", 8'hBB, 1'b1, 2'd1, 1'b0);
        mode = 2'b10;
        tick();
        chk_out("fix_to_rr", 8'hAA, 1'b1, 2'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
